// File: rtl/signed_divider.sv
// Sequential signed DW/VW divider: sign-magnitude restoring division, one quotient
// bit per clock, start/done pulse handshake matching the companion multiplier.
module signed_divider #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  input  logic          Divide,
  output logic [DW-1:0] Quotient,
  output logic [VW-1:0] Remainder,
  output logic          Division_Done,
  output logic          Divide_By_Zero,
  output logic          Overflow,
  output logic          Busy
);

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

  // Handshake: a start is the rising edge where Divide=1 while IDLE; Busy rises
  // on that edge and Division_Done pulses for exactly one cycle as Busy falls.
  // Divide outside IDLE is ignored, nothing is queued.
  state_t        state;
  logic [CW-1:0] count;
  logic [DW-1:0] dq;      // dividend magnitude shifting out, quotient bits shifting in
  logic [VW:0]   prem;    // partial remainder, always < |divisor|
  logic [VW:0]   dmag;    // |divisor|, VW+1 bits so the most negative divisor fits
  logic          sign_q;
  logic          sign_r;

  logic [DW:0]   dvd_ext;
  logic [DW:0]   dvd_abs;
  logic [VW:0]   dvs_ext;
  logic [VW:0]   dvs_abs;
  logic [VW:0]   shifted;
  logic [VW+1:0] diff;
  logic [VW-1:0] rmag;

  always_comb begin
    dvd_ext = {dividend[DW-1], dividend};
    dvd_abs = dividend[DW-1] ? -dvd_ext : dvd_ext;
    dvs_ext = {divisor[VW-1], divisor};
    dvs_abs = divisor[VW-1] ? -dvs_ext : dvs_ext;
    shifted = {prem[VW-1:0], dq[DW-1]};
    diff    = {1'b0, shifted} - {1'b0, dmag};
    rmag    = prem[VW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      count          <= '0;
      dq             <= '0;
      prem           <= '0;
      dmag           <= '0;
      sign_q         <= 1'b0;
      sign_r         <= 1'b0;
      Quotient       <= '0;
      Remainder      <= '0;
      Division_Done  <= 1'b0;
      Divide_By_Zero <= 1'b0;
      Overflow       <= 1'b0;
      Busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Division_Done <= 1'b0;
          if (Divide) begin
            sign_q <= dividend[DW-1] ^ divisor[VW-1];
            sign_r <= dividend[DW-1];
            dmag   <= dvs_abs;
            prem   <= '0;
            count  <= '0;
            Busy   <= 1'b1;
            if (divisor == '0) begin
              // Raw dividend is kept so its low byte can be reported as remainder.
              dq    <= dividend;
              state <= DONE;
            end else begin
              dq    <= dvd_abs[DW-1:0];
              state <= DIV;
            end
          end
        end
        DIV: begin
          if (!diff[VW+1]) begin
            prem <= diff[VW:0];
            dq   <= {dq[DW-2:0], 1'b1};
          end else begin
            prem <= shifted;
            dq   <= {dq[DW-2:0], 1'b0};
          end
          count <= count + 1'b1;
          if (count == CW'(DW - 1)) state <= FIX;
        end
        FIX: begin
          Quotient       <= sign_q ? -dq : dq;
          Remainder      <= sign_r ? -rmag : rmag;
          // Only -min / -1 yields a positive magnitude that has no DW-bit encoding.
          Overflow       <= !sign_q && (dq == {1'b1, {(DW-1){1'b0}}});
          Divide_By_Zero <= 1'b0;
          Division_Done  <= 1'b1;
          Busy           <= 1'b0;
          state          <= DONE;
        end
        DONE: begin
          if (!Division_Done) begin
            // Arrived straight from IDLE with a zero divisor.
            Quotient       <= '0;
            Remainder      <= dq[VW-1:0];
            Divide_By_Zero <= 1'b1;
            Overflow       <= 1'b0;
            Division_Done  <= 1'b1;
            Busy           <= 1'b0;
          end else begin
            Division_Done <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_divider.sv
// Self-checking bench for signed_divider: scenario tasks plus a scoreboard that
// pairs each start with its expected result and checks it on Division_Done.
module tb_signed_divider;

  logic        clk;
  logic        rst_n;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        Divide;
  logic [15:0] Quotient;
  logic [7:0]  Remainder;
  logic        Division_Done;
  logic        Divide_By_Zero;
  logic        Overflow;
  logic        Busy;

  int n_checks = 0;
  int n_fail   = 0;

  // {Quotient, Remainder, Divide_By_Zero, Overflow}
  logic [25:0] exp_q[$];
  logic [25:0] last_res = '0;

  signed_divider #(.DW(16), .VW(8)) dut (
    .clk(clk), .rst_n(rst_n), .dividend(dividend), .divisor(divisor),
    .Divide(Divide), .Quotient(Quotient), .Remainder(Remainder),
    .Division_Done(Division_Done), .Divide_By_Zero(Divide_By_Zero),
    .Overflow(Overflow), .Busy(Busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [25:0] model(input logic [15:0] dvd, input logic [7:0] dvs);
    int a;
    int b;
    int q;
    int r;
    logic [15:0] qs;
    logic [7:0]  rs;
    a = int'($signed(dvd));
    b = int'($signed(dvs));
    if (b == 0) begin
      rs = dvd[7:0];
      return {16'h0000, rs, 1'b1, 1'b0};
    end
    q  = a / b;
    r  = a % b;
    qs = q[15:0];
    rs = r[7:0];
    return {qs, rs, 1'b0, (q == 32768)};
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && Division_Done) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got Q=%h R=%h dbz=%b ovf=%b, expected no Done",
                 Quotient, Remainder, Divide_By_Zero, Overflow);
      end else begin
        logic [25:0] e;
        e = exp_q.pop_front();
        if ({Quotient, Remainder, Divide_By_Zero, Overflow} !== e) begin
          n_fail++;
          $display("FAIL result: got Q=%h R=%h dbz=%b ovf=%b, expected Q=%h R=%h dbz=%b ovf=%b",
                   Quotient, Remainder, Divide_By_Zero, Overflow,
                   e[25:10], e[9:2], e[1], e[0]);
        end
        n_checks++;
        if (Busy !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_at_done: got %b, expected 0", Busy);
        end
      end
    end
  end

  // Driver: one division, checking start behaviour and latency.
  task automatic do_div(input logic [15:0] dvd, input logic [7:0] dvs);
    int n;
    int lat;
    logic [25:0] e;
    e = model(dvd, dvs);
    lat = (dvs == 8'h00) ? 1 : 17;
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    Divide   = 1'b1;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    Divide = 1'b0;
    n_checks++;
    if (Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_at_start: got %b, expected 1", Busy);
    end
    n_checks++;
    if ({Quotient, Remainder, Divide_By_Zero, Overflow} !== last_res) begin
      n_fail++;
      $display("FAIL hold_at_start: got %h, expected %h",
               {Quotient, Remainder, Divide_By_Zero, Overflow}, last_res);
    end
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      #1;
      if (Division_Done) break;
    end
    n_checks++;
    if (n !== lat) begin
      n_fail++;
      $display("FAIL latency %h/%h: got %0d edges, expected %0d", dvd, dvs, n, lat);
    end
    last_res = e;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    Divide   = 1'b0;
    dividend = '0;
    divisor  = '0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({Quotient, Remainder, Division_Done, Divide_By_Zero, Overflow, Busy} !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_state: got Q=%h R=%h done=%b dbz=%b ovf=%b busy=%b, expected all 0",
               Quotient, Remainder, Division_Done, Divide_By_Zero, Overflow, Busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_res = '0;
  endtask

  task automatic test_basic();
    do_div(16'h0FA0, 8'h19);   // 4000/25 = 160 r0
    do_div(16'h0064, 8'h07);   // 100/7 = 14 r2
  endtask

  task automatic test_signs();
    do_div(16'hFFF9, 8'h02);   // -7/2 = -3 r-1
    do_div(16'h0007, 8'hFE);   // 7/-2 = -3 r1
    do_div(16'hFFF9, 8'hFE);   // -7/-2 = 3 r-1
  endtask

  task automatic test_round_trip();
    do_div(16'hF380, 8'hE0);   // -3200/-32 = 100
    do_div(16'h4000, 8'h80);   // 16384/-128 = -128
    do_div(16'h3F01, 8'h7F);   // 127*127 / 127
  endtask

  task automatic test_div_zero();
    do_div(16'h0064, 8'h00);
    do_div(16'h0FA0, 8'h19);   // clears Divide_By_Zero
  endtask

  task automatic test_overflow();
    do_div(16'h8000, 8'hFF);
    do_div(16'h8000, 8'h01);
    do_div(16'h7FFF, 8'hFF);
  endtask

  task automatic test_ignore_restart();
    int n;
    int dones;
    @(negedge clk);
    dividend = 16'h0FA0;
    divisor  = 8'h19;
    Divide   = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(16'h0FA0, 8'h19));
    #1;
    Divide = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    dividend = 16'h0001;   // a restart here would give a different result
    divisor  = 8'h01;
    Divide   = 1'b1;
    @(posedge clk);        // edge T+5
    #1;
    Divide = 1'b0;
    dones = 0;
    for (n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (Division_Done) dones++;
    end
    n_checks++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL ignore_busy_start: got %0d Done pulses, expected 1", dones);
    end
    last_res = model(16'h0FA0, 8'h19);
  endtask

  task automatic test_abort();
    int dones;
    @(negedge clk);
    dividend = 16'h0FA0;
    divisor  = 8'h19;
    Divide   = 1'b1;
    @(posedge clk);
    #1;
    Divide = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({Quotient, Remainder, Division_Done, Divide_By_Zero, Overflow, Busy} !== 28'h0) begin
      n_fail++;
      $display("FAIL abort_outputs: got Q=%h R=%h done=%b dbz=%b ovf=%b busy=%b, expected all 0",
               Quotient, Remainder, Division_Done, Divide_By_Zero, Overflow, Busy);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_res = '0;
    dones = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (Division_Done) dones++;
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d Done pulses, expected 0", dones);
    end
    do_div(16'hFC18, 8'h19);   // -1000/25 = -40
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [7:0]  b;
    for (int i = 0; i < 20; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 8'($urandom_range(0, 255));
      if (i % 7 == 3) b = 8'h00;
      do_div(a, b);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_round_trip();
    test_div_zero();
    test_overflow();
    test_ignore_restart();
    test_abort();
    test_random();
    repeat (5) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_results: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/signed_divider.md
Name: signed_divider

Overview:
- Sequential signed 16/8 divider; the inverse companion of the datapath's 8x8 signed multiplier.
- Accepts the 16-bit signed product format, so a multiply result divided by one original operand returns the other operand.
- Sign-magnitude restoring division, one quotient bit per clock.
- Start/done pulse handshake, matching the multiplier's control style.

Parameters:
- DW, 16, dividend and quotient width (two's complement)
- VW, 8, divisor and remainder width (two's complement)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- dividend  in  16  signed dividend, sampled on the start edge
- divisor  in  8  signed divisor, sampled on the start edge
- Divide  in  1  start request, sampled only while idle
- Quotient  out  16  signed quotient, truncated toward zero
- Remainder  out  8  signed remainder; sign follows dividend
- Division_Done  out  1  one-cycle pulse when results update
- Divide_By_Zero  out  1  status of the last completed operation
- Overflow  out  1  status of the last completed operation
- Busy  out  1  high from the start edge until Done

Behaviour:
- Reset (rst_n low, asynchronous):
  - state returns to IDLE
  - Quotient, Remainder, Division_Done, Divide_By_Zero, Overflow and Busy all clear to 0
  - internal counter and working registers clear
- FSM states: IDLE, DIV, FIX, DONE.
- IDLE:
  - Start edge T is the posedge where Divide=1.
  - At T, capture sign_q = dividend[15]^divisor[7] and sign_r = dividend[15].
  - Capture magnitudes: |dividend| in 17 bits, so -32768 is handled; |divisor| in 9 bits, so -128 is handled.
  - Clear the partial remainder and count, set Busy=1, go to DIV.
  - If divisor==0 at T, go directly to DONE:
    - Quotient=0, Remainder=dividend[7:0], Divide_By_Zero=1, Overflow=0.
- DIV (16 cycles, edges T+1..T+16), one restoring step per edge:
  - shift the partial remainder left with the next dividend MSB
  - trial-subtract |divisor|
  - if non-negative, keep the difference and shift in quotient bit 1; else restore and shift in 0
  - count increments; on count==15, go to FIX
- FIX (edge T+17):
  - Quotient = sign_q ? -qmag : qmag
  - Remainder = sign_r ? -rmag : rmag
  - Overflow=1 only when sign_q=0 and qmag=32768 (case -32768 / -1); Quotient is then 16'h8000.
  - Divide_By_Zero=0; go to DONE.
- DONE (one cycle): Division_Done=1, Busy=0, then IDLE.
- Latency:
  - Done is high in the cycle after edge T+17 (17 clocks).
  - Divide-by-zero: Done is high after edge T+1.
- Divide while Busy or in DONE is ignored; no queuing. Divide held high re-starts on the first edge back in IDLE.
- Outputs and flags hold their last values until the next completion. They do not change at start.
- |Remainder| < |divisor| always, so it fits in 8 signed bits.
- Reset mid-operation aborts immediately: no Done pulse, all outputs 0.

Test Plan:
- dividend=16'h0FA0 (4000), divisor=8'h19 (25), Divide pulsed at T -> Busy 1 from T; Done high in the cycle after T+17; Quotient=16'h00A0, Remainder=8'h00, flags 0.
- dividend=16'hFFF9 (-7), divisor=8'h02 -> Quotient=16'hFFFD (-3), Remainder=8'hFF (-1). Then dividend=16'h0007, divisor=8'hFE (-2) -> Quotient=16'hFFFD, Remainder=8'h01.
- Round trip: dividend=16'hF380 (-3200, i.e. -100*32), divisor=8'hE0 (-32) -> Quotient=16'h0064, Remainder=0. Divisor=8'h80 (-128) with dividend=16'h4000 -> Quotient=16'hFF80, Remainder=0.
- dividend=16'h0064, divisor=8'h00 -> Done in the cycle after T+1; Divide_By_Zero=1, Quotient=16'h0000, Remainder=8'h64. The next valid divide clears Divide_By_Zero.
- dividend=16'h8000, divisor=8'hFF -> Overflow=1, Quotient=16'h8000, Remainder=0. dividend=16'h8000, divisor=8'h01 -> Overflow=0, Quotient=16'h8000.
- Start 4000/25, pulse Divide again at T+5 -> ignored, single Done with 16'h00A0. Start again, drop rst_n at T+8 -> all outputs 0 asynchronously, no Done; after release, a new divide completes normally.
